// File: rtl/alu_input_sequencer.sv
// -----------------------------------------------------------------------------
// alu_input_sequencer
//
// Purpose:
//   Input-side sequencer for the ALU demo. Synchronizes and debounces the raw
//   execute (btnC) and clear (btnU) buttons, turns each accepted press into a
//   single-cycle pulse, and walks a LOAD_A -> LOAD_B -> EXEC -> SHOW state
//   machine. The result is one-cycle register-load strobes for reg_A, reg_B
//   and the result register, plus the latched operand byte and opcode.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a level change
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//   DATA_W           operand width
//
// Ports:
//   clk          in   system clock (100 MHz)
//   reset        in   asynchronous, active-high reset
//   btn_execute  in   raw execute button (asynchronous, bouncy)
//   btn_clear    in   raw clear button (asynchronous, bouncy)
//   sw_data      in   operand switches
//   sw_op        in   operation switches
//   result_in    in   current result register value (chained mode only)
//   data_out     out  operand presented to reg_A / reg_B
//   operation    out  opcode latched in EXEC
//   enable_A     out  one-cycle load strobe for reg_A
//   enable_B     out  one-cycle load strobe for reg_B
//   enable_Y     out  one-cycle load strobe for the result register
//   clear        out  one-cycle synchronous clear strobe for A/B/Y
//   stage        out  current state code for the status LEDs
//
// Build option:
//   ALU_CHAIN_RESULT_EN  when defined, an execute press in SHOW loads the
//                        previous result into reg_A and continues at LOAD_B,
//                        so results can be chained into the next calculation.
// -----------------------------------------------------------------------------
module alu_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int DATA_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_execute,
    input  logic              btn_clear,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [3:0]        sw_op,
    input  logic [DATA_W-1:0] result_in,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        operation,
    output logic              enable_A,
    output logic              enable_B,
    output logic              enable_Y,
    output logic              clear,
    output logic [1:0]        stage
);

    // Button lanes inside the packed vectors below.
    localparam int BTN_EXEC = 0;
    localparam int BTN_CLR  = 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        SHOW   = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Button conditioning: 2-flop synchronizer, debouncer, press detector
    // -------------------------------------------------------------------------
    logic [1:0]       btn_raw;
    logic [1:0]       sync_meta;
    logic [1:0]       sync_q;
    logic [1:0]       deb_level;
    logic [1:0]       deb_level_q;
    logic [1:0]       press;
    logic [CNT_W-1:0] deb_cnt [2];

    assign btn_raw = {btn_clear, btn_execute};

    // NOTE: every clocked register uses non-blocking (<=) assignments so all
    // flops sample their inputs from before the edge; blocking assignments here
    // would collapse the synchronizer stages into a single flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta   <= '0;
            sync_q      <= '0;
            deb_level   <= '0;
            deb_level_q <= '0;
            press       <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync_meta <= btn_raw;
            sync_q    <= sync_meta;

            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == deb_level[i]) begin
                    // Any bounce back to the accepted level restarts the count.
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    deb_level[i] <= sync_q[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end

            // Rising edge of the debounced level only: releases and held
            // buttons produce nothing.
            press       <= deb_level & ~deb_level_q;
            deb_level_q <= deb_level;
        end
    end

    // -------------------------------------------------------------------------
    // Operand-entry state machine
    // -------------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] data_d;
    logic [3:0]        op_d;
    logic              en_a_d;
    logic              en_b_d;
    logic              en_y_d;
    logic              clear_d;

    // NOTE: every signal driven here gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        data_d  = data_out;
        op_d    = operation;
        en_a_d  = 1'b0;
        en_b_d  = 1'b0;
        en_y_d  = 1'b0;
        clear_d = 1'b0;

        if (press[BTN_CLR]) begin
            // Clear wins over a simultaneous execute press, even in EXEC.
            clear_d = 1'b1;
            data_d  = '0;
            op_d    = '0;
            state_d = LOAD_A;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (press[BTN_EXEC]) begin
                        data_d  = sw_data;
                        en_a_d  = 1'b1;
                        state_d = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press[BTN_EXEC]) begin
                        data_d  = sw_data;
                        en_b_d  = 1'b1;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    op_d    = sw_op;
                    en_y_d  = 1'b1;
                    state_d = SHOW;
                end
                SHOW: begin
                    if (press[BTN_EXEC]) begin
`ifdef ALU_CHAIN_RESULT_EN
                        data_d  = result_in;
                        en_a_d  = 1'b1;
                        state_d = LOAD_B;
`else
                        state_d = LOAD_A;
`endif
                    end
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= LOAD_A;
            data_out  <= '0;
            operation <= '0;
            enable_A  <= 1'b0;
            enable_B  <= 1'b0;
            enable_Y  <= 1'b0;
            clear     <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_out  <= data_d;
            operation <= op_d;
            enable_A  <= en_a_d;
            enable_B  <= en_b_d;
            enable_Y  <= en_y_d;
            clear     <= clear_d;
        end
    end

    assign stage = state_q;

`ifndef ALU_CHAIN_RESULT_EN
    // result_in only feeds the chained-result path.
    logic unused_result_in;
    assign unused_result_in = ^result_in;
`endif

endmodule

// File: tb/tb_alu_input_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_input_sequencer
//
// Self-checking bench for alu_input_sequencer with DEBOUNCE_CYCLES = 4.
// Directed scenarios cover reset, clean operand entry, bounce rejection, clear
// priority, the SHOW press (both builds of ALU_CHAIN_RESULT_EN) and reset in
// EXEC. A randomized run compares every cycle against a behavioural model
// built from button sample histories and an abstract sequencer state.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_input_sequencer;

    localparam int DEB    = 4;
    localparam int CNT_W  = 3;
    localparam int DATA_W = 8;
    localparam int LAT    = DEB + 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              btn_execute = 1'b0;
    logic              btn_clear = 1'b0;
    logic [DATA_W-1:0] sw_data = '0;
    logic [3:0]        sw_op = '0;
    logic [DATA_W-1:0] result_in = '0;
    logic [DATA_W-1:0] data_out;
    logic [3:0]        operation;
    logic              enable_A;
    logic              enable_B;
    logic              enable_Y;
    logic              clear;
    logic [1:0]        stage;

    int checks = 0;
    int errors = 0;

    alu_input_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CNT_W),
        .DATA_W         (DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_execute(btn_execute),
        .btn_clear  (btn_clear),
        .sw_data    (sw_data),
        .sw_op      (sw_op),
        .result_in  (result_in),
        .data_out   (data_out),
        .operation  (operation),
        .enable_A   (enable_A),
        .enable_B   (enable_B),
        .enable_Y   (enable_Y),
        .clear      (clear),
        .stage      (stage)
    );

    always #5 clk = ~clk;

    // Strobe tallies sampled mid-cycle, plus a count of cycles with more than
    // one strobe high.
    int cnt_a = 0, cnt_b = 0, cnt_y = 0, cnt_c = 0, multi_strobe = 0;
    always @(negedge clk) begin
        cnt_a <= cnt_a + ((enable_A === 1'b1) ? 1 : 0);
        cnt_b <= cnt_b + ((enable_B === 1'b1) ? 1 : 0);
        cnt_y <= cnt_y + ((enable_Y === 1'b1) ? 1 : 0);
        cnt_c <= cnt_c + ((clear === 1'b1) ? 1 : 0);
        if ($countones({enable_A, enable_B, enable_Y, clear}) > 1)
            multi_strobe <= multi_strobe + 1;
    end

    function automatic int strobe_total();
        return cnt_a + cnt_b + cnt_y + cnt_c;
    endfunction

    // -------------------------------------------------------------------------
    // Helpers (stimulus only)
    // -------------------------------------------------------------------------
    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        btn_execute = 1'b0;
        btn_clear = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts rising edges from the first one that samples the new inputs until
    // a strobe appears; edges = 0 means none within the limit.
    task automatic wait_strobe(input int limit, output int edges, output logic [3:0] which);
        edges = 0;
        which = '0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if ({enable_A, enable_B, enable_Y, clear} != 4'b0000) begin
                edges = i;
                which = {enable_A, enable_B, enable_Y, clear};
                break;
            end
        end
    endtask

    task automatic press_release_exec();
        @(negedge clk);
        btn_execute = 1'b1;
        settle(12);
        btn_execute = 1'b0;
        settle(12);
    endtask

    // -------------------------------------------------------------------------
    // Behavioural reference model
    // -------------------------------------------------------------------------
    logic [1:0]        m_hist1, m_hist2;   // raw samples one and two edges back
    logic [1:0]        m_level, m_level_prev, m_pulse;
    int                m_run [2];
    int                m_state;            // 0..3 = load A, load B, exec, show
    logic [DATA_W-1:0] m_data;
    logic [3:0]        m_op;
    logic              m_en_a, m_en_b, m_en_y, m_clear;

    task automatic model_reset();
        m_hist1 = '0; m_hist2 = '0;
        m_level = '0; m_level_prev = '0; m_pulse = '0;
        m_run[0] = 0; m_run[1] = 0;
        m_state = 0; m_data = '0; m_op = '0;
        m_en_a = 1'b0; m_en_b = 1'b0; m_en_y = 1'b0; m_clear = 1'b0;
    endtask

    // Advances the model by one rising edge using the inputs present at it.
    task automatic model_edge();
        logic [1:0] raw_now;
        logic [1:0] next_pulse;
        raw_now = {btn_clear, btn_execute};
        m_en_a = 1'b0; m_en_b = 1'b0; m_en_y = 1'b0; m_clear = 1'b0;

        if (m_pulse[1]) begin
            m_clear = 1'b1; m_data = '0; m_op = '0; m_state = 0;
        end else if (m_state == 0) begin
            if (m_pulse[0]) begin m_data = sw_data; m_en_a = 1'b1; m_state = 1; end
        end else if (m_state == 1) begin
            if (m_pulse[0]) begin m_data = sw_data; m_en_b = 1'b1; m_state = 2; end
        end else if (m_state == 2) begin
            m_op = sw_op; m_en_y = 1'b1; m_state = 3;
        end else if (m_pulse[0]) begin
`ifdef ALU_CHAIN_RESULT_EN
            m_data = result_in; m_en_a = 1'b1; m_state = 1;
`else
            m_state = 0;
`endif
        end

        next_pulse   = m_level & ~m_level_prev;
        m_level_prev = m_level;
        // A level is accepted once DEB consecutive synchronized samples differ
        // from the currently accepted level.
        for (int i = 0; i < 2; i++) begin
            if (m_hist2[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_level[i] = m_hist2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_hist2 = m_hist1;
        m_hist1 = raw_now;
        m_pulse = next_pulse;
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        checks++;
        if (operation !== 4'h0) begin errors++; $display("FAIL reset_operation: got %h expected 0", operation); end
        checks++;
        if ({enable_A, enable_B, enable_Y, clear} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 0000", {enable_A, enable_B, enable_Y, clear});
        end
        checks++;
        if (stage !== 2'd0) begin errors++; $display("FAIL reset_stage: got %0d expected 0", stage); end
        settle(2);
        reset = 1'b0;
        settle(2);
    endtask

    task automatic test_clean_entry();
        int edges;
        logic [3:0] which;
        int snap;

        @(negedge clk);
        sw_data = 8'h12; sw_op = 4'b0011;
        btn_execute = 1'b1;
        wait_strobe(30, edges, which);
        checks++;
        if (edges != LAT) begin errors++; $display("FAIL entry_a_latency: got %0d expected %0d", edges, LAT); end
        checks++;
        if (which !== 4'b1000) begin errors++; $display("FAIL entry_a_strobe: got %b expected 1000", which); end
        checks++;
        if (data_out !== 8'h12) begin errors++; $display("FAIL entry_a_data: got %h expected 12", data_out); end
        checks++;
        if (stage !== 2'd1) begin errors++; $display("FAIL entry_a_stage: got %0d expected 1", stage); end
        @(posedge clk); #1;
        checks++;
        if (enable_A !== 1'b0) begin errors++; $display("FAIL entry_a_width: got %b expected 0", enable_A); end

        @(negedge clk);
        btn_execute = 1'b0;
        snap = strobe_total();
        settle(14);
        checks++;
        if (strobe_total() != snap) begin
            errors++; $display("FAIL entry_release_quiet: got %0d strobes expected 0", strobe_total() - snap);
        end

        sw_data = 8'h34;
        btn_execute = 1'b1;
        wait_strobe(30, edges, which);
        checks++;
        if (edges != LAT || which !== 4'b0100) begin
            errors++; $display("FAIL entry_b_strobe: got edge %0d strobe %b expected edge %0d strobe 0100", edges, which, LAT);
        end
        checks++;
        if (data_out !== 8'h34 || stage !== 2'd2) begin
            errors++; $display("FAIL entry_b_state: got data %h stage %0d expected data 34 stage 2", data_out, stage);
        end
        @(posedge clk); #1;
        checks++;
        if ({enable_A, enable_B, enable_Y, clear} !== 4'b0010 || operation !== 4'b0011 || stage !== 2'd3) begin
            errors++;
            $display("FAIL entry_exec: got strobes %b op %b stage %0d expected strobes 0010 op 0011 stage 3",
                     {enable_A, enable_B, enable_Y, clear}, operation, stage);
        end
        @(posedge clk); #1;
        checks++;
        if (enable_Y !== 1'b0 || stage !== 2'd3) begin
            errors++; $display("FAIL entry_show: got enable_Y %b stage %0d expected 0 and 3", enable_Y, stage);
        end
        @(negedge clk);
        btn_execute = 1'b0;
        settle(14);
    endtask

    task automatic test_show_press();
        int edges;
        logic [3:0] which;

        @(negedge clk);
        result_in = 8'h46;
        btn_execute = 1'b1;
        wait_strobe(20, edges, which);
`ifdef ALU_CHAIN_RESULT_EN
        checks++;
        if (edges != LAT || which !== 4'b1000) begin
            errors++; $display("FAIL show_chain_strobe: got edge %0d strobe %b expected edge %0d strobe 1000", edges, which, LAT);
        end
        checks++;
        if (data_out !== 8'h46 || stage !== 2'd1) begin
            errors++; $display("FAIL show_chain_state: got data %h stage %0d expected data 46 stage 1", data_out, stage);
        end
`else
        checks++;
        if (edges != 0) begin errors++; $display("FAIL show_no_strobe: got strobe %b at edge %0d expected none", which, edges); end
        checks++;
        if (stage !== 2'd0 || data_out !== 8'h34 || operation !== 4'b0011) begin
            errors++; $display("FAIL show_return: got stage %0d data %h op %b expected stage 0 data 34 op 0011",
                               stage, data_out, operation);
        end
`endif
        @(negedge clk);
        btn_execute = 1'b0;
        settle(14);
    endtask

    task automatic test_clear_priority();
        int edges;
        logic [3:0] which;
        int snap_b;

`ifndef ALU_CHAIN_RESULT_EN
        sw_data = 8'h5A;
        press_release_exec();
`endif
        checks++;
        if (stage !== 2'd1) begin errors++; $display("FAIL clear_pre_stage: got %0d expected 1", stage); end

        snap_b = cnt_b;
        @(negedge clk);
        btn_execute = 1'b1;
        btn_clear = 1'b1;
        wait_strobe(30, edges, which);
        checks++;
        if (edges != LAT || which !== 4'b0001) begin
            errors++; $display("FAIL clear_strobe: got edge %0d strobe %b expected edge %0d strobe 0001", edges, which, LAT);
        end
        checks++;
        if (stage !== 2'd0 || data_out !== 8'h00 || operation !== 4'h0) begin
            errors++; $display("FAIL clear_state: got stage %0d data %h op %h expected 0 00 0", stage, data_out, operation);
        end
        settle(20);
        btn_execute = 1'b0;
        btn_clear = 1'b0;
        settle(14);
        checks++;
        if (cnt_b != snap_b) begin errors++; $display("FAIL clear_no_enable_b: got %0d pulses expected 0", cnt_b - snap_b); end
    endtask

    task automatic test_bounce();
        int edges;
        logic [3:0] which;
        int snap_total, snap_a, t, gap;
        logic [DATA_W-1:0] val;

        val = DATA_W'($urandom);
        @(negedge clk);
        sw_data = val;
        snap_total = strobe_total();
        t = 0;
        while (t < 20) begin
            btn_execute = ~btn_execute;
            gap = $urandom_range(1, 3);
            repeat (gap) @(negedge clk);
            t += gap;
        end
        if (btn_execute) begin
            btn_execute = 1'b0;
            settle(2);
        end
        checks++;
        if (strobe_total() != snap_total) begin
            errors++; $display("FAIL bounce_quiet: got %0d strobes expected 0", strobe_total() - snap_total);
        end

        snap_a = cnt_a;
        btn_execute = 1'b1;
        wait_strobe(30, edges, which);
        checks++;
        if (edges != LAT || which !== 4'b1000 || data_out !== val) begin
            errors++; $display("FAIL bounce_press: got edge %0d strobe %b data %h expected edge %0d strobe 1000 data %h",
                               edges, which, data_out, LAT, val);
        end
        settle(100);
        checks++;
        if (cnt_a != snap_a + 1) begin errors++; $display("FAIL bounce_hold: got %0d enable_A pulses expected 1", cnt_a - snap_a); end
        btn_execute = 1'b0;
        settle(14);
    endtask

    task automatic test_reset_exec();
        int edges;
        logic [3:0] which;
        int snap_y, snap_all;

        @(negedge clk);
        sw_op = 4'b1010;
        btn_execute = 1'b1;
        wait_strobe(30, edges, which);
        checks++;
        if (which !== 4'b0100 || stage !== 2'd2) begin
            errors++; $display("FAIL rexec_reach: got strobe %b stage %0d expected 0100 and 2", which, stage);
        end
        snap_y = cnt_y;
        #1;
        reset = 1'b1;
        btn_execute = 1'b0;
        #1;
        checks++;
        if (stage !== 2'd0 || operation !== 4'h0 || data_out !== 8'h00 || enable_B !== 1'b0) begin
            errors++; $display("FAIL rexec_async: got stage %0d op %h data %h enable_B %b expected 0 0 00 0",
                               stage, operation, data_out, enable_B);
        end
        settle(2);
        reset = 1'b0;
        snap_all = strobe_total();
        settle(14);
        checks++;
        if (cnt_y != snap_y || strobe_total() != snap_all || stage !== 2'd0) begin
            errors++; $display("FAIL rexec_lost: got enable_Y %0d strobes %0d stage %0d expected 0 0 0",
                               cnt_y - snap_y, strobe_total() - snap_all, stage);
        end
    endtask

    task automatic test_random();
        int hold_e, hold_c;
        logic [17:0] got, exp;

        do_reset();
        model_reset();
        hold_e = 3;
        hold_c = 20;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (--hold_e <= 0) begin
                btn_execute = ~btn_execute;
                hold_e = $urandom_range(1, 10);
            end
            if (--hold_c <= 0) begin
                btn_clear = ~btn_clear;
                hold_c = btn_clear ? $urandom_range(1, 10) : $urandom_range(5, 60);
            end
            sw_data   = DATA_W'($urandom);
            sw_op     = 4'($urandom);
            result_in = DATA_W'($urandom);
            @(posedge clk);
            model_edge();
            #1;
            got = {data_out, operation, enable_A, enable_B, enable_Y, clear, stage};
            exp = {m_data, m_op, m_en_a, m_en_b, m_en_y, m_clear, 2'(m_state)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_cycle_%0d: got data %h op %h str %b stage %0d expected data %h op %h str %b stage %0d",
                         cyc, data_out, operation, {enable_A, enable_B, enable_Y, clear}, stage,
                         m_data, m_op, {m_en_a, m_en_b, m_en_y, m_clear}, m_state);
            end
        end
        @(negedge clk);
        btn_execute = 1'b0;
        btn_clear = 1'b0;
        settle(14);
    endtask

    initial begin
        test_reset();
        test_clean_entry();
        test_show_press();
        test_clear_priority();
        test_bounce();
        test_reset_exec();
        test_random();
        checks++;
        if (multi_strobe != 0) begin
            errors++; $display("FAIL strobe_exclusive: got %0d cycles with overlapping strobes expected 0", multi_strobe);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a scenario stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_input_sequencer.md
Name: alu_input_sequencer

Overview:
- Input-side counterpart to the display path: conditions the raw execute/clear buttons and sequences operand entry for the ALU.
- Debounces and synchronizes btnC/btnU, converts presses to single-cycle pulses, and steps a load-A → load-B → execute → show state machine.
- Emits register enables, the latched operand byte and the latched opcode to reg_A/reg_B/result logic. Replaces the ad-hoc alu_controller wiring in top.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples needed to accept a button level change (10 ms at 100 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- DATA_W, 8, operand width.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- btn_execute  in  1  raw btnC, asynchronous, bouncy
- btn_clear  in  1  raw btnU, asynchronous, bouncy
- sw_data  in  DATA_W  operand switches sw[15:8]
- sw_op  in  4  operation switches sw[3:0]
- result_in  in  DATA_W  current Y register value (used only with ALU_CHAIN_RESULT_EN)
- data_out  out  DATA_W  operand presented to reg_A/reg_B data_in
- operation  out  4  opcode latched at execute
- enable_A  out  1  one-cycle load strobe for reg_A
- enable_B  out  1  one-cycle load strobe for reg_B
- enable_Y  out  1  one-cycle load strobe for result register
- clear  out  1  one-cycle synchronous clear strobe for A/B/Y registers
- stage  out  2  current state code, for LED status

Behaviour:
- Reset (asynchronous): all outputs 0, state LOAD_A (stage=0), synchronizers/debounced levels 0, counters 0.
- Synchronizer: two-flop synchronizer per button. Timing is counted from the first rising clk edge that samples the new raw level.
- Debouncer, per button:
  - Counter increments while the synchronized level differs from the debounced level.
  - Counter clears to 0 whenever the levels match (a bounce restarts the count).
  - The debounced level flips on the edge where the counter reaches DEBOUNCE_CYCLES-1; the counter clears on that same edge.
- Press pulse: registered rising-edge detect of the debounced level, high exactly 1 cycle. Release generates nothing. Holding a button generates no repeats.
- Latency: a raw level held stable produces its enable/clear strobe exactly DEBOUNCE_CYCLES+4 rising edges after the raw edge.
- States: LOAD_A(0), LOAD_B(1), EXEC(2), SHOW(3). All strobes are registered, asserted the cycle after the press pulse, and held for exactly 1 cycle.
- LOAD_A + exec press: data_out<=sw_data, enable_A=1, go LOAD_B.
- LOAD_B + exec press: data_out<=sw_data, enable_B=1, go EXEC.
- EXEC: unconditional 1-cycle state. operation<=sw_op, enable_Y=1 during the following cycle, go SHOW.
- SHOW + exec press: go LOAD_A, no strobes. data_out and operation hold.
- Clear press in any state, including EXEC:
  - clear=1 for 1 cycle; data_out<=0, operation<=0; go LOAD_A.
  - Any simultaneous execute press is discarded (clear has priority).
  - No other strobe is issued in that cycle.
- data_out and operation change only on load/execute/clear and otherwise hold.
- At most one of enable_A/enable_B/enable_Y/clear is high in any cycle.
- Reset mid-debounce or mid-strobe: the strobe drops immediately, and the in-progress press is lost.

Optional Feature:
- ALU_CHAIN_RESULT_EN defined: SHOW + exec press sets data_out<=result_in, enable_A=1 and goes to LOAD_B. The previous result becomes operand A for chained calculation.
- Undefined: SHOW behaves as above (return to LOAD_A, no strobe), and result_in is ignored.

Test Plan:
- All benches use DEBOUNCE_CYCLES=4.
- Reset: assert reset asynchronously mid-cycle → all outputs 0 and stage=0 before the next clk edge.
- Clean entry: sw_data=0x12, press execute → enable_A pulse with data_out=0x12 at edge 8 (1 cycle wide), stage=1. Then sw_data=0x34, press → enable_B with data_out=0x34, stage=2. Next cycle enable_Y=1 with operation=sw_op=4'b0011, then stage=3.
- Bounce: toggle btn_execute at 1–3 cycle spacing for 20 cycles, then hold high → exactly one enable_A, issued DEBOUNCE_CYCLES+4 edges after the final rising edge. Held button for 100 cycles → no second strobe.
- Clear priority: raw execute and raw clear rise on the same edge while in LOAD_B → clear=1, enable_B never asserted, stage=0, data_out=0.
- SHOW press: without macro, press in SHOW → stage=0 with no strobe. With ALU_CHAIN_RESULT_EN and result_in=0x46 → enable_A with data_out=0x46, stage=1.
- Reset during EXEC → enable_Y never asserted, stage=0, operation=0.
